// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
// Shared types and helpers for the serial shift engine.
//   t_serial_state : engine state (Ready = idle, Transmit = shifting a word)
//   calc_half_div  : number of in_clk cycles per serial_clk half period,
//                    floor(main_hz / serial_hz / 2), never less than 1
// ----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [0:0] {
        Ready    = 1'b0,
        Transmit = 1'b1
    } t_serial_state;

    function automatic int calc_half_div(input int main_hz, input int serial_hz);
        int half;
        if (serial_hz <= 0) begin
            return 1;
        end
        half = main_hz / serial_hz / 2;
        return (half < 1) ? 1 : half;
    endfunction

endpackage

// File: rtl/serial_clkgen.sv
// ----------------------------------------------------------------------------
// serial_clkgen
// Divides in_clk down to serial_clk: serial_clk toggles once every HALF
// in_clk cycles, so its period is 2*HALF in_clk cycles with 50% duty.
// Ports:
//   in_clk     in   main clock (divider source)
//   in_rst     in   asynchronous, active-high reset
//   serial_clk out  divided clock; sits at IDLE_LEVEL while in reset
// Parameters:
//   HALF       in_clk cycles per serial_clk half period (>= 1)
//   IDLE_LEVEL serial_clk level during and right after reset
// ----------------------------------------------------------------------------
module serial_clkgen #(
    parameter int   HALF       = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic in_clk,
    input  logic in_rst,
    output logic serial_clk
);

    // One bit of counter is kept even when HALF = 1 so the compare below
    // stays well formed; the counter then simply stays at zero.
    localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] div_cnt_reg;
    logic          serial_clk_reg;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            div_cnt_reg    <= '0;
            serial_clk_reg <= IDLE_LEVEL;
        end else if (div_cnt_reg == LAST) begin
            div_cnt_reg    <= '0;
            serial_clk_reg <= ~serial_clk_reg;
        end else begin
            div_cnt_reg    <= div_cnt_reg + CW'(1);
        end
    end

    assign serial_clk = serial_clk_reg;

endmodule

// File: rtl/serial.sv
// ----------------------------------------------------------------------------
// serial
// SPI-style master shift engine: full-duplex, BITS-wide words, words streamed
// back to back while in_enable stays high.
// Ports:
//   in_clk            in   main clock, divided down to serial_clk
//   in_rst            in   asynchronous, active-high reset
//   in_enable         in   transfer enable (hold high to stream words)
//   in_parallel       in   word to transmit, captured when its bit 0 goes out
//   in_serial         in   serial data from the device
//   out_serial        out  serial data to the device
//   out_parallel      out  last complete received word
//   out_word_finished out  one serial_clk period pulse after a word completes
//   out_next_word     out  high while the last bit of a word is on the line
//   out_ready         out  high while idle
//   out_clk           out  serial clock to the device (gated when idle)
// Build option:
//   SERIAL_SYNC_ENABLE_EN  when defined, in_enable is passed through a 2-flop
//                          synchronizer clocked on the output edge; otherwise
//                          in_enable must already be in the serial_clk domain.
// ----------------------------------------------------------------------------
module serial
    import serial_pkg::*;
#(
    parameter int BITS                    = 8,
    parameter int LOWBIT_FIRST            = 1,
    parameter int MAIN_CLK_HZ             = 50_000_000,
    parameter int SERIAL_CLK_HZ           = 10_000_000,
    parameter int SERIAL_CLK_INACTIVE     = 1,
    parameter int SERIAL_DATA_INACTIVE    = 0,
    parameter int KEEP_SERIAL_CLK_RUNNING = 0,
    parameter int FROM_FPGA_FALLING_EDGE  = 1,
    parameter int TO_FPGA_FALLING_EDGE    = 1
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_enable,
    input  logic [BITS-1:0] in_parallel,
    input  logic            in_serial,
    output logic            out_serial,
    output logic [BITS-1:0] out_parallel,
    output logic            out_word_finished,
    output logic            out_next_word,
    output logic            out_ready,
    output logic            out_clk
);

    localparam int               HALF      = calc_half_div(MAIN_CLK_HZ, SERIAL_CLK_HZ);
    localparam int               CNT_W     = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BITS - 1);
    localparam logic             IDLE_CLK  = (SERIAL_CLK_INACTIVE != 0);
    localparam logic             IDLE_DATA = (SERIAL_DATA_INACTIVE != 0);

    // ------------------------------------------------------------------
    // Clocks. The shift logic runs on rising edges of tx_clk / rx_clk,
    // which are serial_clk inverted where the falling edge was selected.
    // ------------------------------------------------------------------
    logic serial_clk;
    logic tx_clk;
    logic rx_clk;

    serial_clkgen #(
        .HALF       (HALF),
        .IDLE_LEVEL (IDLE_CLK)
    ) u_clkgen (
        .in_clk     (in_clk),
        .in_rst     (in_rst),
        .serial_clk (serial_clk)
    );

    assign tx_clk = (FROM_FPGA_FALLING_EDGE != 0) ? ~serial_clk : serial_clk;
    assign rx_clk = (TO_FPGA_FALLING_EDGE   != 0) ? ~serial_clk : serial_clk;

    // ------------------------------------------------------------------
    // Enable, optionally synchronized into the output-edge domain.
    // ------------------------------------------------------------------
    logic enable_int;

`ifdef SERIAL_SYNC_ENABLE_EN
    logic [1:0] enable_sync_reg;

    always_ff @(posedge tx_clk or posedge in_rst) begin
        if (in_rst) begin
            enable_sync_reg <= '0;
        end else begin
            enable_sync_reg <= {enable_sync_reg[0], in_enable};
        end
    end

    assign enable_int = enable_sync_reg[1];
`else
    assign enable_int = in_enable;
`endif

    // ------------------------------------------------------------------
    // Transmit side: state, bit counter and TX shift register, all on the
    // output edge. bit_cnt_reg is the index of the bit currently on the
    // line; the edge that loads a word also puts its first bit out.
    // ------------------------------------------------------------------
    t_serial_state   state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [BITS-1:0]  tx_shift_reg, tx_shift_next;
    logic [BITS-1:0]  tx_shift_adv;
    logic             last_bit;

    assign last_bit = (bit_cnt_reg == LAST_BIT);

    // The outgoing bit always sits at one end of the register; advancing
    // moves the next bit into that position.
    genvar gi;
    generate
        for (gi = 0; gi < BITS; gi++) begin : g_tx_adv
            if (LOWBIT_FIRST != 0) begin : g_lsb
                if (gi == BITS - 1) begin : g_top
                    assign tx_shift_adv[gi] = 1'b0;
                end else begin : g_mid
                    assign tx_shift_adv[gi] = tx_shift_reg[gi+1];
                end
            end else begin : g_msb
                if (gi == 0) begin : g_bot
                    assign tx_shift_adv[gi] = 1'b0;
                end else begin : g_mid
                    assign tx_shift_adv[gi] = tx_shift_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge tx_clk or posedge in_rst) begin
        if (in_rst) begin
            state_reg    <= Ready;
            bit_cnt_reg  <= '0;
            tx_shift_reg <= '0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            tx_shift_reg <= tx_shift_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_shift_next = tx_shift_reg;
        unique case (state_reg)
            Ready: begin
                if (enable_int) begin
                    state_next    = Transmit;
                    bit_cnt_next  = '0;
                    tx_shift_next = in_parallel;
                end
            end
            Transmit: begin
                if (!enable_int) begin
                    // Dropping enable during the last bit ends the word cleanly;
                    // dropping it earlier abandons the word.
                    state_next   = Ready;
                    bit_cnt_next = '0;
                end else if (last_bit) begin
                    // Roll straight into the next word with no gap.
                    bit_cnt_next  = '0;
                    tx_shift_next = in_parallel;
                end else begin
                    bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
                    tx_shift_next = tx_shift_adv;
                end
            end
            default: begin
                state_next   = Ready;
                bit_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive side, on the sample edge. The sample edge always lands after
    // the output edge that launched the bit (half a period later, or on the
    // following output edge when both use the same edge), so bit_cnt_reg
    // here still names the bit being sampled.
    // ------------------------------------------------------------------
    logic [BITS-1:0] rx_shift_reg;
    logic [BITS-1:0] rx_shift_next;
    logic [BITS-1:0] parallel_reg;
    logic            word_finished_reg;
    logic            word_done;

    assign word_done = (state_reg == Transmit) && last_bit;

    generate
        for (gi = 0; gi < BITS; gi++) begin : g_rx_shift
            if (LOWBIT_FIRST != 0) begin : g_lsb
                // First bit received drifts down to bit 0.
                if (gi == BITS - 1) begin : g_top
                    assign rx_shift_next[gi] = in_serial;
                end else begin : g_mid
                    assign rx_shift_next[gi] = rx_shift_reg[gi+1];
                end
            end else begin : g_msb
                // First bit received drifts up to bit BITS-1.
                if (gi == 0) begin : g_bot
                    assign rx_shift_next[gi] = in_serial;
                end else begin : g_mid
                    assign rx_shift_next[gi] = rx_shift_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge rx_clk or posedge in_rst) begin
        if (in_rst) begin
            rx_shift_reg      <= '0;
            parallel_reg      <= '0;
            word_finished_reg <= 1'b0;
        end else begin
            word_finished_reg <= word_done;
            if (state_reg == Transmit) begin
                rx_shift_reg <= rx_shift_next;
            end
            // Publish the word including the bit sampled at this very edge.
            if (word_done) begin
                parallel_reg <= rx_shift_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic tx_bit;

    assign tx_bit = (LOWBIT_FIRST != 0) ? tx_shift_reg[0] : tx_shift_reg[BITS-1];

    assign out_serial        = (state_reg == Transmit) ? tx_bit : IDLE_DATA;
    assign out_parallel      = parallel_reg;
    assign out_word_finished = word_finished_reg;
    assign out_next_word     = word_done;
    assign out_ready         = (state_reg == Ready);
    assign out_clk           = ((state_reg == Transmit) || (KEEP_SERIAL_CLK_RUNNING != 0))
                               ? serial_clk : IDLE_CLK;

endmodule

// File: tb/tb_serial.sv
// ----------------------------------------------------------------------------
// tb_serial
// Two engines in loopback (out_serial fed back to in_serial): one MSB first,
// one LSB first, sharing clock, reset, enable and parallel input. Expected
// line values come from the words themselves and the nominal divider timing
// (serial period = 2 * floor(50 MHz / 10 MHz / 2) in_clk cycles).
// ----------------------------------------------------------------------------
module tb_serial;

    localparam int HALF_TB   = 50_000_000 / 10_000_000 / 2;
    localparam int PERIOD_TB = 2 * HALF_TB;

    logic       in_clk = 1'b0;
    logic       in_rst = 1'b0;
    logic       in_enable = 1'b0;
    logic [7:0] in_parallel = 8'h00;

    wire        ser_m, ser_l;
    wire        clk_m, clk_l;
    wire        rdy_m, rdy_l;
    wire        wf_m, wf_l;
    wire        nw_m, nw_l;
    wire [7:0]  par_m, par_l;

    int checks = 0;
    int errors = 0;
    int tick   = 0;

    logic [7:0] model_par = 8'h00;
    logic [7:0] tx_q[$];

    serial #(.LOWBIT_FIRST(0)) dut_msb (
        .in_clk            (in_clk),
        .in_rst            (in_rst),
        .in_enable         (in_enable),
        .in_parallel       (in_parallel),
        .in_serial         (ser_m),
        .out_serial        (ser_m),
        .out_parallel      (par_m),
        .out_word_finished (wf_m),
        .out_next_word     (nw_m),
        .out_ready         (rdy_m),
        .out_clk           (clk_m)
    );

    serial #(.LOWBIT_FIRST(1)) dut_lsb (
        .in_clk            (in_clk),
        .in_rst            (in_rst),
        .in_enable         (in_enable),
        .in_parallel       (in_parallel),
        .in_serial         (ser_l),
        .out_serial        (ser_l),
        .out_parallel      (par_l),
        .out_word_finished (wf_l),
        .out_next_word     (nw_l),
        .out_ready         (rdy_l),
        .out_clk           (clk_l)
    );

    always #5 in_clk = ~in_clk;

    // in_clk rising edges since reset release; serial_clk falls when
    // tick % PERIOD_TB == HALF_TB and rises when tick % PERIOD_TB == 0.
    always @(posedge in_clk or posedge in_rst) begin
        if (in_rst) tick <= 0;
        else        tick <= tick + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_of(input logic [7:0] w, input int i);
        return 1'((w >> i) & 8'h01);
    endfunction

    // Park on the in_clk falling edge just after the next serial_clk fall.
    task automatic wait_tx_edge();
        int n = 0;
        do begin
            @(negedge in_clk);
            n++;
        end while (((tick % PERIOD_TB) != HALF_TB) && (n < 4 * PERIOD_TB));
    endtask

    // Send tx_q[0 .. nwords-1] back to back, checking every bit period.
    task automatic stream(input int nwords);
        logic [7:0] w;
        wait_tx_edge();
        in_parallel = tx_q[0];
        in_enable   = 1'b1;
        for (int j = 0; j < nwords; j++) begin
            w = tx_q[j];
            for (int k = 0; k < 8; k++) begin
                wait_tx_edge();
                chk("bit_msb", {15'd0, ser_m}, {15'd0, bit_of(w, 7 - k)});
                chk("bit_lsb", {15'd0, ser_l}, {15'd0, bit_of(w, k)});
                chk("busy", {14'd0, rdy_m, rdy_l}, 16'd0);
                chk("next_word", {14'd0, nw_m, nw_l}, (k == 7) ? 16'd3 : 16'd0);
                chk("word_finished", {14'd0, wf_m, wf_l}, (k == 0 && j > 0) ? 16'd3 : 16'd0);
                if (k == 0 && j > 0) model_par = tx_q[j-1];
                chk("parallel_msb", {8'd0, par_m}, {8'd0, model_par});
                chk("parallel_lsb", {8'd0, par_l}, {8'd0, model_par});
                chk("clk_low", {14'd0, clk_m, clk_l}, 16'd0);
                if (k == 7) begin
                    if (j < nwords - 1) in_parallel = tx_q[j+1];
                    else                in_enable   = 1'b0;
                end
                // Half period low, then high: 4-cycle period, 50% duty.
                @(negedge in_clk);
                chk("clk_low_hold", {14'd0, clk_m, clk_l}, 16'd0);
                @(negedge in_clk);
                chk("clk_high", {14'd0, clk_m, clk_l}, 16'd3);
            end
        end
        wait_tx_edge();
        model_par = tx_q[nwords-1];
        chk("stop_ready", {14'd0, rdy_m, rdy_l}, 16'd3);
        chk("stop_serial_idle", {14'd0, ser_m, ser_l}, 16'd0);
        chk("stop_word_finished", {14'd0, wf_m, wf_l}, 16'd3);
        chk("stop_next_word", {14'd0, nw_m, nw_l}, 16'd0);
        chk("stop_parallel_msb", {8'd0, par_m}, {8'd0, model_par});
        chk("stop_parallel_lsb", {8'd0, par_l}, {8'd0, model_par});
        chk("stop_clk_gated", {14'd0, clk_m, clk_l}, 16'd3);
        wait_tx_edge();
        chk("wf_fall", {14'd0, wf_m, wf_l}, 16'd0);
        $display("stream of %0d word(s) ending 0x%02h, checks=%0d errors=%0d",
                 nwords, model_par, checks, errors);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, {14'd0, rdy_m, rdy_l}, 16'd3);
        chk({tag, "_clk"}, {14'd0, clk_m, clk_l}, 16'd3);
        chk({tag, "_serial"}, {14'd0, ser_m, ser_l}, 16'd0);
        chk({tag, "_wf"}, {14'd0, wf_m, wf_l}, 16'd0);
        chk({tag, "_nw"}, {14'd0, nw_m, nw_l}, 16'd0);
        chk({tag, "_par"}, {par_m, par_l}, {model_par, model_par});
    endtask

    initial begin
        int n;
        in_rst = 1'b1;
        repeat (3) @(negedge in_clk);
        check_idle("reset");
        in_rst = 1'b0;

        // Idle after reset: clock gated high for several serial periods.
        for (int i = 0; i < 12; i++) begin
            @(negedge in_clk);
            chk("idle_clk", {14'd0, clk_m, clk_l}, 16'd3);
        end
        check_idle("idle");

        // Single word 0xA5.
        tx_q = {8'hA5};
        stream(1);

        // Two words streamed: 0x03 then 0x12.
        tx_q = {8'h03, 8'h12};
        stream(2);

        // Single word 0x01.
        tx_q = {8'h01};
        stream(1);

        // Random streams.
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(1, 4);
            tx_q = {};
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            stream(n);
        end

        // Reset in the middle of a word (while bit 4 is on the line).
        wait_tx_edge();
        in_parallel = 8'hC3;
        in_enable   = 1'b1;
        for (int k = 0; k < 5; k++) wait_tx_edge();
        chk("pre_reset_bit4_msb", {15'd0, ser_m}, {15'd0, bit_of(8'hC3, 3)});
        in_rst = 1'b1;
        #1;
        model_par = 8'h00;
        check_idle("midword_reset");
        in_enable = 1'b0;
        repeat (3) @(negedge in_clk);
        in_rst = 1'b0;
        $display("mid-word reset applied, checks=%0d errors=%0d", checks, errors);

        // Restart after the reset must begin at bit 0.
        tx_q = {8'h5E, 8'h81};
        stream(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
